// File: rtl/accum_summator.sv
// accum_summator
//   Accumulator that sits behind the board keys and switches. Two debounced
//   push-buttons trigger LOAD or ACCUMULATE (add/subtract) of the switch operand.
//   The block keeps a sticky overflow flag and a wrapping count of accepted
//   operations. The accumulator and the counter also drive active-low
//   7-segment buses.
//
// Ports
//   clk      system clock, rising edge
//   button0  asynchronous active-low reset
//   button1  LOAD key, active-low, asynchronous to clk
//   button2  ACCUMULATE key, active-low, asynchronous to clk
//   sub      0 = add, 1 = subtract (sampled with the ACCUMULATE event)
//   switch   operand (sampled in the event cycle)
//   acc      accumulator value
//   ovf      sticky overflow (cleared by LOAD or reset)
//   busy     high while the FSM is not IDLE
//   cnt      accepted-operation counter, wraps
//   hex_acc  segments of acc, digit i in [7i+6:7i]
//   hex_cnt  segments of cnt, same packing
//
// FSM states
//   state      | meaning
//   S_IDLE     | waiting for a key press event
//   S_EXEC     | one cycle: apply latched operation, bump counter
//   S_WAIT_REL | waiting for both debounced keys to be released

module accum_summator #(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   button0,
    input  logic                   button1,
    input  logic                   button2,
    input  logic                   sub,
    input  logic [WIDTH-1:0]       switch,
    output logic [WIDTH-1:0]       acc,
    output logic                   ovf,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt,
    output logic [7*(WIDTH/4)-1:0] hex_acc,
    output logic [7*(CNT_W/4)-1:0] hex_cnt
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT_REL} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB} op_t;

    // ---------------------------------------------------------------
    // Key path: index 0 = LOAD (button1), index 1 = ACCUMULATE (button2)
    // ---------------------------------------------------------------
    logic [1:0]       w_key_raw;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_stable;
    logic [1:0]       r_press;
    logic [DEB_W-1:0] r_deb [2];

    assign w_key_raw = {button2, button1};

    // The press pulse is registered together with the stable-level flip.
    // It is therefore high exactly in the first cycle the stable level reads 0.
    always_ff @(posedge clk or negedge button0) begin
        if (!button0) begin
            r_meta   <= '1;
            r_sync   <= '1;
            r_stable <= '1;
            r_press  <= '0;
            for (int k = 0; k < 2; k++) begin
                r_deb[k] <= '0;
            end
        end else begin
            r_meta <= w_key_raw;
            r_sync <= r_meta;
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync[k] == r_stable[k]) begin
                    r_deb[k] <= '0;
                end else if (r_deb[k] == DEB_TC) begin
                    r_deb[k]    <= '0;
                    r_stable[k] <= r_sync[k];
                    r_press[k]  <= ~r_sync[k];
                end else begin
                    r_deb[k] <= r_deb[k] + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk or negedge button0) begin
        if (!button0) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (|r_press) w_state_nxt = S_EXEC;
            S_EXEC:     w_state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (&r_stable) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    op_t              r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_v;

    always_comb begin
        w_sum    = {1'b0, r_acc} + {1'b0, r_operand};
        w_diff   = {1'b0, r_acc} - {1'b0, r_operand};
        w_is_sub = (r_op == OP_SUB);
        w_res    = w_is_sub ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
    end

    generate
        if (SIGNED != 0) begin : g_ovf_signed
            // Add overflows when like-signed operands produce a result of the
            // other sign; subtract overflows when the operand signs differ and
            // the result sign moves away from acc.
            assign w_v = (w_is_sub ? (r_acc[WIDTH-1] != r_operand[WIDTH-1])
                                   : (r_acc[WIDTH-1] == r_operand[WIDTH-1]))
                         && (w_res[WIDTH-1] != r_acc[WIDTH-1]);
        end else begin : g_ovf_unsigned
            // Bit WIDTH of the extended difference is the borrow (operand > acc).
            assign w_v = w_is_sub ? w_diff[WIDTH] : w_sum[WIDTH];
        end
    endgenerate

    // LOAD has priority when both keys produce an event in the same cycle.
    always_ff @(posedge clk or negedge button0) begin
        if (!button0) begin
            r_op      <= OP_LOAD;
            r_operand <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (r_press[0]) begin
                    r_op      <= OP_LOAD;
                    r_operand <= switch;
                end else if (r_press[1]) begin
                    r_op      <= sub ? OP_SUB : OP_ADD;
                    r_operand <= switch;
                end
            end
            if (r_state == S_EXEC) begin
                if (r_op == OP_LOAD) begin
                    r_acc <= r_operand;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_res;
                    r_ovf <= r_ovf | w_v;
                end
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign acc  = r_acc;
    assign ovf  = r_ovf;
    assign cnt  = r_cnt;
    assign busy = (r_state != S_IDLE);

    // ---------------------------------------------------------------
    // 7-segment decode, active-low, bit order g..a
    // ---------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < WIDTH / 4; gi++) begin : g_hex_acc
            assign hex_acc[7*gi +: 7] = seg7(r_acc[4*gi +: 4]);
        end
        for (genvar gc = 0; gc < CNT_W / 4; gc++) begin : g_hex_cnt
            assign hex_cnt[7*gc +: 7] = seg7(r_cnt[4*gc +: 4]);
        end
    endgenerate

endmodule

// File: tb/tb_accum_summator.sv
// Bench for accum_summator. It runs an unsigned and a signed instance side by
// side on shared keys and switches. Each stimulus pushes its expected result
// into a queue. A monitor pops an entry when busy rises and compares the
// outputs on the following cycle.

module tb_accum_summator;

    logic       clk;
    logic       button0, button1, button2, sub;
    logic [7:0] switch;

    logic [7:0]  acc_u, acc_s, cnt_u, cnt_s;
    logic        ovf_u, ovf_s, busy_u, busy_s;
    logic [13:0] hex_acc_u, hex_acc_s, hex_cnt_u, hex_cnt_s;

    accum_summator #(.WIDTH(8), .SIGNED(0), .DEB_CYCLES(4), .CNT_W(8)) dut_u (
        .clk(clk), .button0(button0), .button1(button1), .button2(button2),
        .sub(sub), .switch(switch), .acc(acc_u), .ovf(ovf_u), .busy(busy_u),
        .cnt(cnt_u), .hex_acc(hex_acc_u), .hex_cnt(hex_cnt_u)
    );

    accum_summator #(.WIDTH(8), .SIGNED(1), .DEB_CYCLES(4), .CNT_W(8)) dut_s (
        .clk(clk), .button0(button0), .button1(button1), .button2(button2),
        .sub(sub), .switch(switch), .acc(acc_s), .ovf(ovf_s), .busy(busy_s),
        .cnt(cnt_s), .hex_acc(hex_acc_s), .hex_cnt(hex_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic       ovf_u;
        logic       ovf_s;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] exp_cnt = 8'h00;
    logic       abort_mode = 1'b0;

    localparam logic [13:0] HEX_00 = 14'b1000000_1000000;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] hex2(input logic [7:0] v);
        return {seg(v[7:4]), seg(v[3:0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] a, input logic ou, input logic os);
        exp_cnt = exp_cnt + 8'h01;
        q.push_back('{acc: a, ovf_u: ou, ovf_s: os, cnt: exp_cnt});
    endtask

    // Keys are held for 'hold' cycles. switch/sub are then scrambled before
    // release, so any late sampling of the operand would show up in acc.
    task automatic press(input logic k_load, input logic k_acc, input int hold);
        @(negedge clk);
        if (k_load) button1 = 1'b0;
        if (k_acc)  button2 = 1'b0;
        repeat (hold) @(negedge clk);
        switch  = ~switch;
        sub     = ~sub;
        button1 = 1'b1;
        button2 = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        switch = v;
        push(v, 1'b0, 1'b0);
        press(1'b1, 1'b0, 10);
    endtask

    task automatic do_acc(input logic s, input logic [7:0] v, input logic [7:0] a,
                          input logic ou, input logic os);
        sub    = s;
        switch = v;
        push(a, ou, os);
        press(1'b0, 1'b1, 10);
    endtask

    // Monitor: busy rising marks the EXEC cycle (outputs still old). The
    // operation result must be visible one cycle later.
    initial begin : monitor
        logic prev;
        exp_t e;
        exp_t last;
        prev = 1'b0;
        last = '{acc: 8'h00, ovf_u: 1'b0, ovf_s: 1'b0, cnt: 8'h00};
        forever begin
            @(posedge clk);
            #1;
            if (button0 && busy_u && !prev && !abort_mode) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_op: busy rose with no pending op, cnt=0x%0h", cnt_u);
                end else begin
                    e = q.pop_front();
                    check("exec_acc_unchanged", acc_u, last.acc);
                    check("exec_cnt_unchanged", cnt_u, last.cnt);
                    check("busy_s_exec", busy_s, 1);
                    @(posedge clk);
                    #1;
                    check("acc_u", acc_u, e.acc);
                    check("ovf_u", ovf_u, e.ovf_u);
                    check("cnt_u", cnt_u, e.cnt);
                    check("acc_s", acc_s, e.acc);
                    check("ovf_s", ovf_s, e.ovf_s);
                    check("cnt_s", cnt_s, e.cnt);
                    check("hex_acc", hex_acc_u, hex2(e.acc));
                    check("hex_cnt", hex_cnt_u, hex2(e.cnt));
                    check("busy_wait_rel", busy_u, 1);
                    last = e;
                end
            end
            prev = busy_u;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int i;
        button0 = 1'b0;
        button1 = 1'b1;
        button2 = 1'b1;
        sub     = 1'b0;
        switch  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc", acc_u, 8'h00);
        check("rst_ovf", ovf_u, 0);
        check("rst_cnt", cnt_u, 8'h00);
        check("rst_busy", busy_u, 0);
        check("rst_hex_acc", hex_acc_u, HEX_00);
        check("rst_hex_cnt", hex_cnt_u, HEX_00);
        @(negedge clk);
        button0 = 1'b1;
        repeat (5) @(negedge clk);

        // Load 0x3C
        do_load(8'h3C);

        // 2-cycle glitch on ACCUMULATE must be filtered out
        @(negedge clk);
        button2 = 1'b0;
        repeat (2) @(negedge clk);
        button2 = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_acc", acc_u, 8'h3C);
        check("glitch_cnt", cnt_u, 8'h01);
        check("glitch_busy", busy_u, 0);

        // 0xF0 + 0x20: unsigned carry, no signed overflow
        do_load(8'hF0);
        do_acc(1'b0, 8'h20, 8'h10, 1'b1, 1'b0);
        // 0x10 - 0x05: no borrow, unsigned ovf sticky
        do_acc(1'b1, 8'h05, 8'h0B, 1'b1, 1'b0);

        // Signed overflow cases
        do_load(8'h7F);
        do_acc(1'b0, 8'h01, 8'h80, 1'b0, 1'b1);
        do_load(8'h80);
        do_acc(1'b1, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Both keys fall together; LOAD wins; long hold must not retrigger
        switch = 8'h11;
        sub    = 1'b0;
        push(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        button1 = 1'b0;
        button2 = 1'b0;
        repeat (100) @(negedge clk);
        check("hold_busy", busy_u, 1);
        check("hold_cnt", cnt_u, 8'h09);
        button1 = 1'b1;
        button2 = 1'b1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_u) break;
        end
        check("release_busy", busy_u, 0);
        repeat (5) @(negedge clk);

        // Drive the counter up to 0xFF, then one more load wraps it to 0
        while (exp_cnt != 8'hFF) do_load(exp_cnt + 8'h21);
        check("cnt_ff", cnt_u, 8'hFF);
        do_load(8'hC3);
        check("cnt_wrap", cnt_u, 8'h00);
        check("hex_cnt_wrap", hex_cnt_u, HEX_00);

        // Put the block in a non-reset state (acc=0x10, ovf=1, cnt=2)
        do_load(8'hF0);
        do_acc(1'b0, 8'h20, 8'h10, 1'b1, 1'b0);

        // Reset asserted during EXEC aborts the load of 0x55
        abort_mode = 1'b1;
        switch = 8'h55;
        @(negedge clk);
        button1 = 1'b0;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_u) break;
        end
        check("abort_in_exec", busy_u, 1);
        button0 = 1'b0;
        #1;
        check("abort_acc", acc_u, 8'h00);
        check("abort_ovf", ovf_u, 0);
        check("abort_cnt", cnt_u, 8'h00);
        check("abort_busy", busy_u, 0);
        check("abort_acc_s", acc_s, 8'h00);
        check("abort_hex_acc", hex_acc_u, HEX_00);
        check("abort_hex_cnt", hex_cnt_u, HEX_00);
        button1 = 1'b1;
        repeat (3) @(negedge clk);
        button0 = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_acc", acc_u, 8'h00);
        check("post_abort_cnt", cnt_u, 8'h00);

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accum_summator.md
Name: accum_summator

Overview:
- Parametrised successor to the board-level summator: WIDTH-bit accumulator driven by debounced push-buttons and a switch bank.
- Operations: load, add/subtract of the switch operand, sticky overflow, wrapping operation counter.
- Accumulator and counter are decoded to active-low 7-segment buses for the HEX displays.
- Sits directly behind board keys/switches, one clock domain.

Parameters:
- WIDTH, 8, accumulator/operand width (multiple of 4, 4..32).
- SIGNED, 0, 0 = unsigned carry/borrow overflow; 1 = two's-complement overflow.
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a key level change (>=2).
- CNT_W, 8, operation counter width (multiple of 4).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- button0  in  1  asynchronous active-low reset.
- button1  in  1  LOAD key, active-low, asynchronous to clk.
- button2  in  1  ACCUMULATE key, active-low, asynchronous to clk.
- sub  in  1  operation select sampled with ACCUMULATE: 0 = add, 1 = subtract.
- switch  in  WIDTH  operand.
- acc  out  WIDTH  accumulator value.
- ovf  out  1  sticky overflow flag.
- busy  out  1  high while FSM is not IDLE.
- cnt  out  CNT_W  accepted-operation counter.
- hex_acc  out  7*(WIDTH/4)  segments of acc; digit i in bits [7i+6:7i] shows acc[4i+3:4i].
- hex_cnt  out  7*(CNT_W/4)  segments of cnt, same packing.

Behaviour:
- Reset (button0 low, async): acc=0, ovf=0, cnt=0, busy=0, FSM=IDLE, synchronisers and stable key levels=1 (released), debounce counters=0, operand/op registers=0. Reset assertion mid-operation aborts the operation; no partial update.
- Key path, per key: 2-FF synchroniser. The debounce counter increments while the synced level differs from the stable level and clears when they match. The stable level flips when the counter reaches DEB_CYCLES-1. A press event is a one-cycle pulse on a stable 1->0 transition. Releases generate no event.
- FSM states: IDLE, EXEC, WAIT_REL.
  - IDLE + load event: latch op=LOAD and operand=switch, go to EXEC.
  - IDLE + accumulate event: latch op=ADD/SUB (from sub) and operand=switch, go to EXEC.
  - Simultaneous events: LOAD wins; the accumulate event is dropped.
  - EXEC (one cycle):
    - LOAD: acc<=operand, ovf<=0.
    - ADD/SUB: acc<=acc±operand mod 2^WIDTH. ovf<=ovf | v.
      - SIGNED=0: v = carry-out (add) or borrow (operand>acc, sub).
      - SIGNED=1: v = operand signs equal (add) or differ (sub) and result sign differs from acc sign.
    - All ops: cnt<=cnt+1, wrapping 2^CNT_W-1 -> 0. Then go to WAIT_REL.
  - WAIT_REL: stay until both stable key levels are 1, then IDLE.
  - Events arriving in EXEC/WAIT_REL are discarded, not queued.
- Latency: event pulse at cycle t; FSM in EXEC at t+1; acc/ovf/cnt valid from t+2. busy=1 from t+1 until return to IDLE.
- switch and sub are sampled only in the event cycle; later changes do not affect the operation.
- Segment encoding: active-low, bit order g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Decode is combinational from registered acc/cnt.
- ovf clears only on LOAD or reset.

Test Plan:
- Reset with DEB_CYCLES=4, WIDTH=8 -> acc=0x00, ovf=0, cnt=0, busy=0, hex_acc=14'b1000000_1000000.
- switch=0x3C, press button1 for 10 cycles -> acc=0x3C two cycles after the event pulse, cnt=1, ovf=0. A 2-cycle glitch on button2 yields no event and no change.
- acc=0xF0, switch=0x20, sub=0, press button2 (SIGNED=0) -> acc=0x10, ovf=1. Then sub=1, switch=0x05, press -> acc=0x0B, ovf stays 1.
- SIGNED=1: load 0x7F, add 0x01 -> acc=0x80, ovf=1. Load 0x80 -> ovf=0. Subtract 0x01 -> acc=0x7F, ovf=1.
- button1 and button2 fall in the same cycle -> only LOAD executes, cnt+1. Hold keys low 100 cycles -> busy stays 1 and no second operation occurs. After release, busy=0.
- cnt=0xFF then one load -> cnt=0x00. Assert button0 during EXEC -> all outputs return to reset values immediately.
